// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: arbitrates the instruction-fetch unit (IFU) and the
// load/store unit (LSU) onto one shared memory read port, allowing at most
// one outstanding read at a time.
// Build option CONFIG_ARB_RR_EN: when defined, simultaneous requests are
// resolved round-robin; when undefined, the LSU always has priority over the IFU.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // instruction-fetch requester
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  // load/store requester
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  // shared memory port
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    SEL_IFU = 1'b0,
    SEL_LSU = 1'b1
  } sel_t;

  state_t            state;
  sel_t              grant;
  logic [ADDR_W-1:0] addr_q;

  logic              any_req_c;
  sel_t              pick_c;
  logic              grant_rready_c;

  // At least one requester wants the memory port
  always_comb begin
    any_req_c = ifu_arvalid | lsu_arvalid;
  end

`ifdef CONFIG_ARB_RR_EN
  sel_t last_grant;

  // Round-robin selection: on a tie the requester not granted last wins
  always_comb begin
    pick_c = SEL_IFU;
    if (ifu_arvalid && lsu_arvalid) begin
      pick_c = (last_grant == SEL_IFU) ? SEL_LSU : SEL_IFU;
    end else if (lsu_arvalid) begin
      pick_c = SEL_LSU;
    end
  end

  // Last-grant pointer, advanced on every grant; points at IFU out of reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= SEL_IFU;
    end else if ((state == ST_IDLE) && any_req_c) begin
      last_grant <= pick_c;
    end
  end
`else
  // Fixed priority: LSU wins whenever it requests
  always_comb begin
    pick_c = lsu_arvalid ? SEL_LSU : SEL_IFU;
  end
`endif

  // rready of whichever requester owns the current transaction
  always_comb begin
    grant_rready_c = (grant == SEL_LSU) ? lsu_rready : ifu_rready;
  end

  // Transaction FSM: grant and address latch in IDLE, address phase, data phase
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= ST_IDLE;
      grant  <= SEL_IFU;
      addr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req_c) begin
            state  <= ST_ADDR;
            grant  <= pick_c;
            addr_q <= (pick_c == SEL_LSU) ? lsu_araddr : ifu_araddr;
          end
        end
        ST_ADDR: begin
          if (mem_arready) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_rvalid && grant_rready_c) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output steering; everything is held at zero while reset is asserted
  always_comb begin
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    mem_arvalid = 1'b0;
    mem_araddr  = '0;
    mem_rready  = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    lsu_rdata   = '0;
    if (reset) begin
      // read data fans out unconditionally; only rvalid is steered
      ifu_rdata = mem_rdata;
      lsu_rdata = mem_rdata;
      case (state)
        ST_IDLE: begin
          if (any_req_c) begin
            ifu_arready = (pick_c == SEL_IFU);
            lsu_arready = (pick_c == SEL_LSU);
          end
        end
        ST_ADDR: begin
          mem_arvalid = 1'b1;
          mem_araddr  = addr_q;
        end
        ST_DATA: begin
          mem_rready = grant_rready_c;
          ifu_rvalid = mem_rvalid && (grant == SEL_IFU);
          lsu_rvalid = mem_rvalid && (grant == SEL_LSU);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Testbench for mem_rd_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle against a
// transaction-level model.
`timescale 1ns/1ps
module tb_mem_rd_arbiter;

`ifdef CONFIG_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;

  mem_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // Transaction-level model: one optional in-flight read
  bit          m_active = 0;
  bit          m_who = 0;        // 0 = IFU, 1 = LSU
  bit          m_addr_done = 0;
  bit          m_last = 0;       // last granted requester
  logic [31:0] m_addr = '0;
  int          grant_log[$];
  logic [31:0] addr_log[$];

  // handshakes seen in the cycle just ended, used by the stimulus agents
  bit f_ifu_ar = 0, f_lsu_ar = 0, f_mem_ar = 0, f_mem_r = 0;

  bit          e_ifu_arready, e_lsu_arready, e_mem_arvalid, e_mem_rready;
  bit          e_ifu_rvalid, e_lsu_rvalid, win_valid, win, gr_rready;
  logic [31:0] e_rdata;

  // Every-cycle comparison against the model, then model advance
  always @(negedge clock) begin
    e_ifu_arready = 0; e_lsu_arready = 0; e_mem_arvalid = 0; e_mem_rready = 0;
    e_ifu_rvalid = 0; e_lsu_rvalid = 0; win_valid = 0; win = 0; gr_rready = 0;
    e_rdata = reset ? mem_rdata : 32'h0;
    if (reset) begin
      if (!m_active) begin
        if (ifu_arvalid && lsu_arvalid) begin
          win_valid = 1;
          win = RR_BUILD ? !m_last : 1'b1;
        end else if (ifu_arvalid || lsu_arvalid) begin
          win_valid = 1;
          win = lsu_arvalid;
        end
        if (win_valid) begin
          if (win) e_lsu_arready = 1; else e_ifu_arready = 1;
        end
      end else if (!m_addr_done) begin
        e_mem_arvalid = 1;
      end else begin
        gr_rready = m_who ? lsu_rready : ifu_rready;
        e_mem_rready = gr_rready;
        if (m_who) e_lsu_rvalid = mem_rvalid; else e_ifu_rvalid = mem_rvalid;
      end
    end
    chk("ifu_arready", ifu_arready, e_ifu_arready);
    chk("lsu_arready", lsu_arready, e_lsu_arready);
    chk("mem_arvalid", mem_arvalid, e_mem_arvalid);
    chk("mem_rready", mem_rready, e_mem_rready);
    chk("ifu_rvalid", ifu_rvalid, e_ifu_rvalid);
    chk("lsu_rvalid", lsu_rvalid, e_lsu_rvalid);
    chk("ifu_rdata", ifu_rdata, e_rdata);
    chk("lsu_rdata", lsu_rdata, e_rdata);
    if (e_mem_arvalid) chk("mem_araddr", mem_araddr, m_addr);
    else if (!reset) chk("mem_araddr_rst", mem_araddr, 32'h0);

    f_ifu_ar = ifu_arvalid && ifu_arready;
    f_lsu_ar = lsu_arvalid && lsu_arready;
    f_mem_ar = mem_arvalid && mem_arready;
    f_mem_r  = mem_rvalid && mem_rready;

    if (!reset) begin
      m_active = 0; m_last = 0;
    end else if (!m_active) begin
      if (win_valid) begin
        m_active = 1; m_who = win; m_addr_done = 0; m_last = win;
        m_addr = win ? lsu_araddr : ifu_araddr;
        grant_log.push_back(int'(win));
      end
    end else if (!m_addr_done) begin
      if (mem_arready) begin
        m_addr_done = 1;
        addr_log.push_back(m_addr);
      end
    end else if (mem_rvalid && gr_rready) begin
      m_active = 0;
    end
  end

  // Stimulus agent state
  bit          rand_mode = 0;
  bit          ifu_hold = 0, lsu_hold = 0;
  int          ar_delay = 0, r_delay = 0, ar_cnt = 0, r_cnt = 0;
  bit          pend = 0;
  logic [31:0] pend_data = '0, next_data = '0;

  // Advance one cycle and let the requester / memory agents respond
  task automatic step();
    @(posedge clock);
    #1;
    if (rand_mode) reset = ($urandom % 600) != 0;
    if (f_ifu_ar) begin
      if (ifu_hold) ifu_araddr = ifu_araddr + 32'd4; else ifu_arvalid = 0;
    end
    if (f_lsu_ar) begin
      if (lsu_hold) lsu_araddr = lsu_araddr + 32'd4; else lsu_arvalid = 0;
    end
    if (rand_mode) begin
      if (!ifu_arvalid && ($urandom % 3 == 0)) begin
        ifu_arvalid = 1; ifu_araddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_arvalid && ($urandom % 3 == 0)) begin
        lsu_arvalid = 1; lsu_araddr = $urandom & 32'hFFFF_FFFC;
      end
      ifu_rready = ($urandom % 4) != 0;
      lsu_rready = ($urandom % 4) != 0;
    end
    if (!reset) begin
      pend = 0; mem_rvalid = 0; mem_arready = 0; ar_cnt = 0;
    end else begin
      if (f_mem_ar) begin
        pend = 1; ar_cnt = 0;
        r_cnt = rand_mode ? int'($urandom % 4) : r_delay;
        pend_data = rand_mode ? $urandom : next_data;
      end
      if (rand_mode) mem_arready = ($urandom % 3) == 0;
      else if (mem_arvalid) begin
        mem_arready = (ar_cnt >= ar_delay);
        ar_cnt++;
      end else mem_arready = 0;
      if (pend && f_mem_r) begin
        pend = 0; mem_rvalid = 0;
      end
      if (pend) begin
        if (r_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = pend_data;
        end else begin
          r_cnt--; mem_rvalid = 0; mem_rdata = $urandom;
        end
      end else begin
        mem_rvalid = rand_mode && ($urandom % 5 == 0);
        mem_rdata = $urandom;
      end
    end
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  int  n;
  bit  saw;

  initial begin
    reset = 0;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 1;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_rready = 1;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = '0;

    // Reset holds every output low despite active inputs
    step();
    ifu_arvalid = 1; lsu_arvalid = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    mem_arready = 1;
    sample();
    chk("rst_ifu_arready", ifu_arready, 0);
    chk("rst_lsu_arready", lsu_arready, 0);
    chk("rst_mem_rready", mem_rready, 0);
    chk("rst_ifu_rdata", ifu_rdata, 0);
    step();
    ifu_arvalid = 0; lsu_arvalid = 0; mem_rvalid = 0; mem_arready = 0; reset = 1;
    sample();

    // IFU-only read, memory address accept after 2 cycles
    step();
    ar_delay = 2; r_delay = 1; next_data = 32'h0000_0413;
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
    sample();
    chk("t1_ifu_arready", ifu_arready, 1);
    chk("t1_lsu_arready", lsu_arready, 0);
    step(); sample();
    chk("t1_mem_arvalid", mem_arvalid, 1);
    chk("t1_mem_araddr", mem_araddr, 32'h8000_0000);
    n = 0; saw = 0;
    while (!ifu_rvalid && n < 20) begin
      step(); sample(); saw |= lsu_rvalid; n++;
    end
    chk("t1_ifu_rvalid", ifu_rvalid, 1);
    chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk("t1_latency", n, 4);
    chk("t1_lsu_rvalid_never", saw, 0);
    step(); sample();

    // Simultaneous IFU and LSU request: LSU first, IFU next
    grant_log.delete(); addr_log.delete();
    ar_delay = 0; r_delay = 0; next_data = 32'hA5A5_0001;
    step();
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1;
    lsu_araddr = 32'h8000_1000; lsu_arvalid = 1;
    sample();
    chk("t2_lsu_arready", lsu_arready, 1);
    chk("t2_ifu_arready", ifu_arready, 0);
    n = 0;
    while (!(grant_log.size() >= 2 && !m_active) && n < 40) begin step(); sample(); n++; end
    chk("t2_grants", grant_log.size(), 2);
    chk("t2_first", grant_log[0], 1);
    chk("t2_second", grant_log[1], 0);
    chk("t2_addr0", addr_log[0], 32'h8000_1000);
    chk("t2_addr1", addr_log[1], 32'h8000_0004);

    // Both requesters held for four transactions
    grant_log.delete(); addr_log.delete();
    ifu_hold = 1; lsu_hold = 1;
    step();
    ifu_araddr = 32'h8000_0100; ifu_arvalid = 1;
    lsu_araddr = 32'h8000_2000; lsu_arvalid = 1;
    sample();
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin step(); sample(); n++; end
    chk("t3_grants", grant_log.size() >= 4, 1);
    chk("t3_g0", grant_log[0], 1);
    chk("t3_g1", grant_log[1], RR_BUILD ? 0 : 1);
    chk("t3_g2", grant_log[2], 1);
    chk("t3_g3", grant_log[3], RR_BUILD ? 0 : 1);
    ifu_hold = 0; lsu_hold = 0;
    n = 0;
    while ((ifu_arvalid || lsu_arvalid || m_active) && n < 100) begin step(); sample(); n++; end
    chk("t3_drained", ifu_arvalid || lsu_arvalid || m_active, 0);

    // Granted rready held low while data is waiting
    step();
    lsu_rready = 0; lsu_araddr = 32'h8000_3000; lsu_arvalid = 1; next_data = 32'h0000_BEEF;
    sample();
    n = 0;
    while (!lsu_rvalid && n < 20) begin step(); sample(); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_rvalid", lsu_rvalid, 1);
      chk("t4_hold_mem_rready", mem_rready, 0);
      if (i < 2) begin step(); sample(); end
    end
    step(); lsu_rready = 1; sample();
    chk("t4_rel_mem_rready", mem_rready, 1);
    chk("t4_rel_rdata", lsu_rdata, 32'h0000_BEEF);
    step(); sample();
    chk("t4_done_rvalid", lsu_rvalid, 0);
    chk("t4_done_mem_rready", mem_rready, 0);

    // Spurious memory data while idle
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    sample();
    chk("t5_ifu_rvalid", ifu_rvalid, 0);
    chk("t5_lsu_rvalid", lsu_rvalid, 0);
    chk("t5_mem_rready", mem_rready, 0);
    chk("t5_ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);

    // Reset asserted mid-transaction, then a fresh request
    addr_log.delete();
    r_delay = 3;
    step();
    lsu_araddr = 32'h8000_4000; lsu_arvalid = 1;
    sample();
    n = 0;
    while (addr_log.size() == 0 && n < 20) begin step(); sample(); n++; end
    step(); sample();
    chk("t6_in_data", mem_rready, 1);
    step(); reset = 0; sample();
    chk("t6_rst_mem_rready", mem_rready, 0);
    chk("t6_rst_lsu_rvalid", lsu_rvalid, 0);
    step(); reset = 1; sample();
    chk("t6_idle_mem_arvalid", mem_arvalid, 0);
    chk("t6_idle_mem_rready", mem_rready, 0);
    step();
    r_delay = 0; next_data = 32'h1111_2222;
    ifu_araddr = 32'h8000_0010; ifu_arvalid = 1;
    sample();
    chk("t6_restart_arready", ifu_arready, 1);
    step(); sample();
    chk("t6_restart_mem_araddr", mem_araddr, 32'h8000_0010);
    n = 0;
    while (!ifu_rvalid && n < 20) begin step(); sample(); n++; end
    chk("t6_restart_rdata", ifu_rdata, 32'h1111_2222);
    step(); sample();

    // Randomized traffic with occasional reset
    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0;
    reset = 1;
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 ADDR_W, 32, address width of all araddr ports.
REQ-002 DATA_W, 32, data width of all rdata ports.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-005 ifu_arvalid  input  1  instruction-fetch (icache) read request.
REQ-006 ifu_arready  output  1  IFU address accepted.
REQ-007 ifu_araddr  input  ADDR_W  IFU read address.
REQ-008 ifu_rvalid  output  1  IFU read data valid.
REQ-009 ifu_rready  input  1  IFU ready for data.
REQ-010 ifu_rdata  output  DATA_W  IFU read data.
REQ-011 lsu_arvalid  input  1  load/store unit read request.
REQ-012 lsu_arready  output  1  LSU address accepted.
REQ-013 lsu_araddr  input  ADDR_W  LSU read address.
REQ-014 lsu_rvalid  output  1  LSU read data valid.
REQ-015 lsu_rready  input  1  LSU ready for data.
REQ-016 lsu_rdata  output  DATA_W  LSU read data.
REQ-017 mem_arvalid  output  1  shared memory read request.
REQ-018 mem_arready  input  1  memory address accepted.
REQ-019 mem_araddr  output  ADDR_W  shared memory read address.
REQ-020 mem_rvalid  input  1  memory data valid.
REQ-021 mem_rready  output  1  ready for memory data.
REQ-022 mem_rdata  input  DATA_W  memory read data.

Function
REQ-023 The block SHALL implement the states IDLE, ADDR and DATA, with at most one outstanding memory read.
REQ-024 In IDLE with at least one arvalid high, the block SHALL select one requester, assert that requester's arready combinationally in the same cycle, latch its araddr and the grant, and enter ADDR.
REQ-025 In ADDR the block SHALL drive mem_arvalid=1 and mem_araddr=latched address, holding both stable until mem_arready; mem_arvalid&&mem_arready SHALL move the FSM to DATA.
REQ-026 In DATA the block SHALL route mem_rvalid to the granted rvalid and the granted rready to mem_rready.
REQ-027 In DATA, a handshake (mem_rvalid && granted rready) SHALL return the FSM to IDLE; a new grant is possible in the following cycle.
REQ-028 ifu_rdata and lsu_rdata SHALL both equal mem_rdata at all times; only the rvalid outputs are gated by the grant.
REQ-029 The non-granted requester SHALL see arready=0 and rvalid=0 for the whole transaction.
REQ-030 Both arready outputs SHALL be 0 outside IDLE.
REQ-031 mem_rvalid seen in IDLE or ADDR SHALL be ignored: mem_rready=0 and no rvalid is forwarded.
REQ-032 Minimum latency SHALL be: request accepted in cycle 0, mem_arvalid high in cycle 1, data forwarded combinationally in the cycle mem_rvalid arrives.
REQ-033 Whichever requester is not selected SHALL keep its request pending and be re-evaluated in the next IDLE cycle.

Reset
REQ-034 While reset=0 the block SHALL force the state to IDLE, drive every output to 0, clear the latched address to 0, and set the last-grant pointer to IFU.
REQ-035 Reset during ADDR or DATA SHALL abandon the transaction without forwarding any data; the memory side is required to be reset in the same cycle.

Configuration
REQ-036 With CONFIG_ARB_RR_EN defined, selection on simultaneous requests SHALL be round-robin: the requester not granted last wins, and the pointer updates on every grant.
REQ-037 With CONFIG_ARB_RR_EN undefined, selection SHALL be fixed priority, with LSU over IFU; IFU starvation under continuous LSU requests is accepted.

Verification
REQ-038 IFU-only request, araddr=0x80000000, mem_arready after 2 cycles, mem_rdata=0x00000413 -> ifu_arready in cycle 0, mem_araddr=0x80000000, ifu_rvalid=1 with ifu_rdata=0x00000413, lsu_rvalid=0 throughout.
REQ-039 IFU (0x80000004) and LSU (0x80001000) request in the same cycle after reset -> LSU is served first in both builds; IFU is served next in the following IDLE.
REQ-040 RR build with both requesters held continuously for 4 transactions -> grants are LSU, IFU, LSU, IFU; fixed build -> LSU x4.
REQ-041 Granted rready held low for 3 cycles while mem_rvalid=1 -> mem_rready=0 and the FSM stays in DATA; it completes on the cycle rready rises.
REQ-042 Spurious mem_rvalid=1 in IDLE -> no rvalid on either side and mem_rready=0.
REQ-043 reset=0 asserted in DATA, then released -> all outputs 0 and the FSM in IDLE; the next request restarts the normal sequence.
